// File: rtl/dmem_responder_if.sv
// Core data-port bundle for the dmem_responder scratch RAM.
// The core drives the master side; the memory responder is the slave.
interface dmem_responder_if;
    logic [31:0] d_addr;
    logic [31:0] data_out;
    logic        wr_req;
    logic [3:0]  wr_mask;
    logic [31:0] data_in;
    logic        addr_err;
    logic        ready;
    logic [15:0] wr_count;

    modport master (
        output d_addr, data_out, wr_req, wr_mask,
        input  data_in, addr_err, ready, wr_count
    );

    modport slave (
        input  d_addr, data_out, wr_req, wr_mask,
        output data_in, addr_err, ready, wr_count
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data scratch RAM with a zero-fill phase after reset, byte-masked
// write-first stores, 1-cycle registered loads and a saturating store counter.
module dmem_responder #(
    parameter int unsigned DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    dmem_responder_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   data_in_q, data_in_d;
    logic          addr_err_q, addr_err_d;
    logic [15:0]   wr_count_q, wr_count_d;

    logic [AW-1:0] idx_s;
    logic          in_range_s;
    logic          ptr_last_s;
    logic          ready_s;
    logic          clr_s;
    logic          store_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   merged_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_wa_s;
    logic [31:0]   mem_wd_s;
    logic          unused_addr_lsb_s;

    assign idx_s             = bus.d_addr[AW+1:2];
    assign in_range_s        = (bus.d_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign ptr_last_s        = (ptr_q == AW'(DEPTH - 1));
    assign rd_word_s         = mem_q[idx_s];
    assign unused_addr_lsb_s = ^bus.d_addr[1:0];

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: leave INIT on the cycle the last word is cleared
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (ptr_last_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // FSM outputs: clear strobe in INIT, accepted-store strobe in RUN
    always_comb begin
        ready_s = 1'b0;
        clr_s   = 1'b0;
        store_s = 1'b0;
        case (state_q)
            ST_INIT: clr_s = 1'b1;
            ST_RUN: begin
                ready_s = 1'b1;
                store_s = bus.wr_req && in_range_s && (bus.wr_mask != 4'h0);
            end
            default: begin
                ready_s = 1'b0;
                clr_s   = 1'b0;
                store_s = 1'b0;
            end
        endcase
    end

    // Byte merge of the store into the addressed word; also the write-first load value
    always_comb begin
        merged_s = rd_word_s;
        for (int b = 0; b < 4; b++) begin
            if (store_s && bus.wr_mask[b]) begin
                merged_s[8*b +: 8] = bus.data_out[8*b +: 8];
            end else begin
                merged_s[8*b +: 8] = rd_word_s[8*b +: 8];
            end
        end
    end

    // Array write port select; held off while reset is asserted so no store commits
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = idx_s;
        mem_wd_s = merged_s;
        if (!rst_n_i) begin
            mem_we_s = 1'b0;
        end else if (clr_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = ptr_q;
            mem_wd_s = 32'h0000_0000;
        end else begin
            mem_we_s = store_s;
        end
    end

    // Storage array, no reset: INIT zero-fills it before READY rises
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[mem_wa_s] <= mem_wd_s;
        end
    end

    // Next-state for pointer, load response and store counter
    always_comb begin
        ptr_d      = ptr_q;
        data_in_d  = 32'h0000_0000;
        addr_err_d = 1'b0;
        wr_count_d = wr_count_q;
        if (clr_s) begin
            ptr_d = ptr_q + AW'(1);
        end else begin
            ptr_d = ptr_q;
        end
        if (ready_s && in_range_s) begin
            data_in_d = merged_s;
        end else if (ready_s) begin
            addr_err_d = 1'b1;
        end else begin
            data_in_d = 32'h0000_0000;
        end
        if (store_s && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q      <= '0;
            data_in_q  <= 32'h0000_0000;
            addr_err_q <= 1'b0;
            wr_count_q <= 16'h0000;
        end else begin
            ptr_q      <= ptr_d;
            data_in_q  <= data_in_d;
            addr_err_q <= addr_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.data_in  = data_in_q;
    assign bus.addr_err = addr_err_q;
    assign bus.ready    = ready_s;
    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH=32, BASE_ADDR=0): directed table,
// reset/INIT sequences, randomized traffic against an array model, counter saturation.
module tb_dmem_responder;
    logic clk;
    logic rst_n;
    dmem_responder_if bus();

    dmem_responder #(.DEPTH(32), .BASE_ADDR(32'h0000_0000)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [15:0] exp_count;
    } vec_t;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] mdl [32];
    int          mdl_cnt;
    logic [31:0] exp_d;
    logic        exp_e;
    vec_t        tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl_cnt = 0;
    endtask

    // Apply one RUN-phase request for one cycle and work out the expected response
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] m);
        int idx;
        bus.d_addr   = a;
        bus.data_out = d;
        bus.wr_req   = w;
        bus.wr_mask  = m;
        if (a < 32'd128) begin
            idx = int'(a / 32'd4);
            if (w && m != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
                if (mdl_cnt < 65535) mdl_cnt++;
            end
            exp_d = mdl[idx];
            exp_e = 1'b0;
        end else begin
            exp_d = 32'h0;
            exp_e = 1'b1;
        end
        step();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data"},  bus.data_in, exp_d);
        check({tag, "_err"},   {31'h0, bus.addr_err}, {31'h0, exp_e});
        check({tag, "_count"}, {16'h0, bus.wr_count}, mdl_cnt[31:0]);
    endtask

    // Count cycles until READY, trying stores the whole time (they must be dropped)
    task automatic init_wait(input string tag);
        int   n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        bus.d_addr = 32'h0; bus.data_out = 32'hFFFF_FFFF; bus.wr_req = 1'b1; bus.wr_mask = 4'hF;
        while (bus.ready !== 1'b1 && n < 40) begin
            if (bus.data_in !== 32'h0 || bus.addr_err !== 1'b0 || bus.wr_count !== 16'h0) bad = 1'b1;
            step();
            n++;
        end
        check({tag, "_init_len"}, n, 32'd32);
        check({tag, "_init_quiet"}, {31'h0, bad}, 32'h0);
        bus.wr_req = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rst_data"},  bus.data_in, 32'h0);
        check({tag, "_rst_err"},   {31'h0, bus.addr_err}, 32'h0);
        check({tag, "_rst_ready"}, {31'h0, bus.ready}, 32'h0);
        check({tag, "_rst_count"}, {16'h0, bus.wr_count}, 32'h0);
    endtask

    initial begin
        tbl[0] = '{32'h0C, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 16'd1};
        tbl[1] = '{32'h0C, 32'h11223344, 1'b1, 4'h5, 32'hDE22BE44, 1'b0, 16'd2};
        tbl[2] = '{32'h0C, 32'h0,        1'b0, 4'h0, 32'hDE22BE44, 1'b0, 16'd2};
        tbl[3] = '{32'h10, 32'hCAFEF00D, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 16'd3};
        tbl[4] = '{32'h80, 32'h99999999, 1'b1, 4'hF, 32'h0,        1'b1, 16'd3};
        tbl[5] = '{32'h00, 32'h0,        1'b0, 4'h0, 32'h0,        1'b0, 16'd3};
        tbl[6] = '{32'h0C, 32'hFFFFFFFF, 1'b1, 4'h0, 32'hDE22BE44, 1'b0, 16'd3};
        tbl[7] = '{32'h0E, 32'h0,        1'b0, 4'h0, 32'hDE22BE44, 1'b0, 16'd3};
        tbl[8] = '{32'h13, 32'h0,        1'b0, 4'h0, 32'hCAFEF00D, 1'b0, 16'd3};

        rst_n = 1'b1;
        bus.d_addr = 32'h0; bus.data_out = 32'h0; bus.wr_req = 1'b0; bus.wr_mask = 4'h0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        step(); step();
        rst_n = 1'b1;
        init_wait("por");

        // every word zeroed by INIT
        for (int i = 0; i < 32; i++) begin
            drive(32'(i * 4), 32'h0, 1'b0, 4'h0);
            check("clear_data", bus.data_in, 32'h0);
            check("clear_err", {31'h0, bus.addr_err}, 32'h0);
        end

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].addr, tbl[i].data, tbl[i].wr, tbl[i].mask);
            check($sformatf("tbl%0d_data", i), bus.data_in, tbl[i].exp_data);
            check($sformatf("tbl%0d_err", i), {31'h0, bus.addr_err}, {31'h0, tbl[i].exp_err});
            check($sformatf("tbl%0d_count", i), {16'h0, bus.wr_count}, {16'h0, tbl[i].exp_count});
        end

        // randomized traffic, mostly in range, with masks and loads mixed in
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a % 32'd128;
            else if (a < 32'd128) a = a + 32'd128;
            drive(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            check_outputs("rnd");
            check("rnd_ready", {31'h0, bus.ready}, 32'h1);
        end

        // reset during a RUN store with non-zero outputs
        drive(32'h14, 32'h5A5A1234, 1'b1, 4'hF);
        check_outputs("pre_rst");
        bus.d_addr = 32'h18; bus.data_out = 32'h00000077; bus.wr_req = 1'b1; bus.wr_mask = 4'hF;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("run");
        step(); step();
        rst_n = 1'b1;
        init_wait("run");
        drive(32'h14, 32'h0, 1'b0, 4'h0);
        check("run_rst_w14", bus.data_in, 32'h0);
        drive(32'h18, 32'h0, 1'b0, 4'h0);
        check("run_rst_w18", bus.data_in, 32'h0);

        // reset when the INIT pointer has reached word 10
        drive(32'h20, 32'hA5A5A5A5, 1'b1, 4'hF);
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.wr_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("init");
        step();
        rst_n = 1'b1;
        init_wait("init");
        drive(32'h20, 32'h0, 1'b0, 4'h0);
        check("init_rst_w20", bus.data_in, 32'h0);

        // store counter saturation
        for (int i = 0; i < 65534; i++) drive(32'h04, 32'(i), 1'b1, 4'hF);
        check("sat_fffe", {16'h0, bus.wr_count}, 32'h0000FFFE);
        drive(32'h04, 32'h1, 1'b1, 4'hF);
        check("sat_ffff", {16'h0, bus.wr_count}, 32'h0000FFFF);
        drive(32'h04, 32'h2, 1'b1, 4'hF);
        drive(32'h04, 32'h3, 1'b1, 4'hF);
        check("sat_hold", {16'h0, bus.wr_count}, 32'h0000FFFF);
        check("sat_data", bus.data_in, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 32, number of 32-bit words; SHALL be a power of two, 4..1024; AW = log2(DEPTH).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; SHALL be aligned to DEPTH*4.
REQ-003 CLK  in  1  single clock, all state on rising edge.
REQ-004 RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-005 D_ADDR  in  32  core data byte address.
REQ-006 DATA_OUT  in  32  core store data.
REQ-007 WR_REQ  in  1  core store request, sampled every cycle.
REQ-008 WR_MASK  in  4  byte enables; bit n covers DATA_OUT[8n+7:8n].
REQ-009 DATA_IN  out  32  registered load data to core.
REQ-010 ADDR_ERR  out  1  registered out-of-range flag, aligned with DATA_IN.
REQ-011 READY  out  1  high when init clear is complete and requests are serviced.
REQ-012 WR_COUNT  out  16  accepted-store counter.

Function
REQ-013 Word index SHALL be D_ADDR[AW+1:2]; D_ADDR[1:0] SHALL be ignored.
REQ-014 In range SHALL mean D_ADDR[31:AW+2] == BASE_ADDR[31:AW+2].
REQ-015 FSM SHALL have two states: INIT, RUN.
REQ-016 INIT: internal pointer 0..DEPTH-1 clears one word to zero per cycle; on the cycle the pointer writes DEPTH-1, next state RUN.
REQ-017 INIT SHALL take exactly DEPTH cycles after reset release; READY=0 throughout INIT, 1 from the first RUN cycle.
REQ-018 In INIT, core stores SHALL be dropped (no array write, no count), DATA_IN=0, ADDR_ERR=0.
REQ-019 RUN store: WR_REQ=1, in range, WR_MASK!=0 -> at the edge, only masked bytes of the indexed word update; unmasked bytes unchanged.
REQ-020 WR_REQ=1 with WR_MASK=0 SHALL be a no-op and not counted.
REQ-021 RUN load: every cycle, DATA_IN at edge N+1 SHALL equal the indexed word as sampled at edge N; latency exactly 1 cycle, no handshake, no stall.
REQ-022 Same-cycle store and load to one word SHALL be write-first: DATA_IN returns the merged post-store word.
REQ-023 Out-of-range address in RUN: store suppressed and not counted; next cycle DATA_IN=0, ADDR_ERR=1 for one cycle per offending cycle.
REQ-024 WR_COUNT SHALL increment by 1 per accepted store (REQ-019) and saturate at 16'hFFFF, no wrap.
REQ-025 No state other than the array, pointer, FSM, DATA_IN, ADDR_ERR, WR_COUNT.

Reset
REQ-026 RESET_N=0 SHALL immediately force: state INIT, pointer 0, DATA_IN=0, ADDR_ERR=0, READY=0, WR_COUNT=0.
REQ-027 Array contents need not reset asynchronously; INIT SHALL zero every word before READY rises.
REQ-028 Reset asserted mid-INIT or mid-RUN (including during a store) SHALL abort; the store SHALL not commit, and INIT SHALL restart at word 0 on release.

Verification
REQ-029 Release reset, DEPTH=32 -> READY low exactly 32 cycles then high; loads of all 32 words return 0, ADDR_ERR=0.
REQ-030 Store 0xDEADBEEF mask 4'hF to 0x0C, then mask 4'b0101 data 0x11223344 to 0x0C, load 0x0C -> 0xDE22BE44 one cycle later; WR_COUNT=2.
REQ-031 Store 0xCAFEF00D mask 4'hF to 0x10 with D_ADDR held at 0x10 -> DATA_IN=0xCAFEF00D next cycle (write-first).
REQ-032 Store to 0x80 (out of range, BASE 0) mask 4'hF -> ADDR_ERR=1 one cycle, DATA_IN=0, WR_COUNT unchanged; word 0 still reads 0.
REQ-033 Store WR_MASK=0 -> no change, WR_COUNT unchanged; force WR_COUNT to 16'hFFFE path by 65537 stores -> holds 16'hFFFF.
REQ-034 Assert RESET_N=0 at INIT pointer 10 and again during a RUN store -> outputs zero asynchronously, INIT restarts, stored word reads 0 after READY.
